// File: rtl/d_phy_scnn_pkg.sv
// D-PHY clock-lane receiver shared types.
// State encoding, LP line codes and default timing constants.
package d_phy_scnn_pkg;

  typedef enum logic [3:0] {
    OFF,
    INIT,
    STOP,
    HS_RQST,
    HS_PREP,
    HS_CLK,
    HS_END,
    ULPS_RQST,
    ULPS,
    ULPS_EXIT,
    ERR
  } state_t;

  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP11 = 2'b11;

  localparam int DEF_LP_FILT       = 2;
  localparam int DEF_T_INIT_CYC    = 100;
  localparam int DEF_T_TERM_EN_CYC = 4;
  localparam int DEF_CLK_MISS_CYC  = 8;
  localparam int DEF_T_WAKEUP_CYC  = 1000;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/d_phy_lp_deglitch.sv
// LP line-code filter: a new code is accepted only after it has
// been sampled LP_FILT times in a row.
module d_phy_lp_deglitch
  import d_phy_scnn_pkg::*;
#(
  parameter int LP_FILT = DEF_LP_FILT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] lp,
  output logic [1:0] lp_filt
);

  localparam int CW = $clog2(LP_FILT + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(LP_FILT);

  logic [1:0]    cand;
  logic [CW-1:0] run;
  logic [CW-1:0] run_d;

  always_comb begin
    run_d = CW'(1);
    if (lp == cand)
      run_d = (run >= RUN_MAX) ? run : run + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand    <= LP11;
      run     <= '0;
      lp_filt <= LP11;
    end else begin
      cand <= lp;
      run  <= run_d;
      if (run_d >= RUN_MAX)
        lp_filt <= lp;
    end
  end

endmodule

// File: rtl/d_phy_scnn.sv
// D-PHY clock-lane receiver control: LP sequencing, HS clock
// detection, ULPS handling and PPI status outputs.
module d_phy_scnn
  import d_phy_scnn_pkg::*;
#(
  parameter int LP_FILT       = DEF_LP_FILT,
  parameter int T_INIT_CYC    = DEF_T_INIT_CYC,
  parameter int T_TERM_EN_CYC = DEF_T_TERM_EN_CYC,
  parameter int CLK_MISS_CYC  = DEF_CLK_MISS_CYC,
  parameter int T_WAKEUP_CYC  = DEF_T_WAKEUP_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] lp,
  input  logic       hs_clk_toggle,
  output logic       stopstate,
  output logic       rx_clk_active_hs,
  output logic       rx_ulps_clk_not,
  output logic       ulps_active_not,
  output logic       hs_term_en,
  output logic       err_control
);

  localparam logic [CNT_W-1:0] T_INIT = CNT_W'(T_INIT_CYC);
  localparam logic [CNT_W-1:0] T_TERM = CNT_W'(T_TERM_EN_CYC);
  localparam logic [CNT_W-1:0] T_MISS = CNT_W'(CLK_MISS_CYC);
  localparam logic [CNT_W-1:0] T_WAKE = CNT_W'(T_WAKEUP_CYC);

  state_t           state;
  state_t           state_d;
  logic [1:0]       lp_filt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] miss;
  logic [CNT_W-1:0] miss_d;
  logic             term_ok;

  d_phy_lp_deglitch #(
    .LP_FILT (LP_FILT)
  ) u_deglitch (
    .clk     (clk),
    .rst     (rst),
    .lp      (lp),
    .lp_filt (lp_filt)
  );

  assign term_ok = (state == HS_PREP) && (cnt >= T_TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      miss  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      miss  <= miss_d;
    end
  end

  always_comb begin
    miss_d = '0;
    if (!hs_clk_toggle)
      miss_d = (miss >= T_MISS) ? miss : miss + 1'b1;
  end

  always_comb begin
    state_d = state;
    case (state)
      OFF: state_d = INIT;
      INIT:
        if (lp_filt == LP11 && sat_inc(cnt) >= T_INIT)
          state_d = STOP;
      STOP:
        case (lp_filt)
          LP01:    state_d = HS_RQST;
          LP10:    state_d = ULPS_RQST;
          LP00:    state_d = ERR;
          default: state_d = STOP;
        endcase
      HS_RQST:
        case (lp_filt)
          LP00:    state_d = HS_PREP;
          LP11:    state_d = STOP;
          LP10:    state_d = ERR;
          default: state_d = HS_RQST;
        endcase
      HS_PREP:
        if (lp_filt == LP11)
          state_d = STOP;
        else if (hs_clk_toggle && term_ok)
          state_d = HS_CLK;
      // LP11 takes priority over clock activity
      HS_CLK:
        if (lp_filt == LP11)
          state_d = STOP;
        else if (miss_d >= T_MISS)
          state_d = HS_END;
      HS_END:
        if (lp_filt == LP11)
          state_d = STOP;
        else if (hs_clk_toggle)
          state_d = HS_CLK;
      ULPS_RQST:
        case (lp_filt)
          LP00:    state_d = ULPS;
          LP11:    state_d = STOP;
          LP01:    state_d = ERR;
          default: state_d = ULPS_RQST;
        endcase
      ULPS:
        case (lp_filt)
          LP10:    state_d = ULPS_EXIT;
          LP01:    state_d = ERR;
          LP11:    state_d = ERR;
          default: state_d = ULPS;
        endcase
      ULPS_EXIT:
        if (lp_filt == LP11)
          state_d = (cnt >= T_WAKE) ? STOP : ERR;
      ERR:
        if (lp_filt == LP11)
          state_d = STOP;
      default: state_d = OFF;
    endcase
    if (!enable)
      state_d = OFF;
  end

  // The Mark-1 cycle that triggers the ULPS exit counts toward wakeup.
  always_comb begin
    cnt_d = '0;
    if (state_d != state) begin
      if (state_d == ULPS_EXIT)
        cnt_d = CNT_W'(1);
    end else begin
      case (state)
        INIT:
          cnt_d = (lp_filt == LP11) ? sat_inc(cnt) : '0;
        HS_PREP,
        ERR:
          cnt_d = sat_inc(cnt);
        ULPS_EXIT:
          cnt_d = (lp_filt == LP10) ? sat_inc(cnt) : cnt;
        default:
          cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    stopstate        = (state == STOP);
    rx_clk_active_hs = (state == HS_CLK);
    rx_ulps_clk_not  = (state != ULPS);
    ulps_active_not  = !((state == ULPS) || (state == ULPS_EXIT));
    hs_term_en       = (state == HS_CLK) || (state == HS_END) || term_ok;
    err_control      = (state == ERR) && (cnt == '0);
  end

endmodule

// File: tb/tb_d_phy_scnn.sv
// Directed scoreboard bench for the D-PHY clock-lane receiver.
// Stimulus queues expectations; a negedge monitor compares them.
module tb_d_phy_scnn;
  import d_phy_scnn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] lp;
  logic       hs_clk_toggle;
  logic       stopstate;
  logic       rx_clk_active_hs;
  logic       rx_ulps_clk_not;
  logic       ulps_active_not;
  logic       hs_term_en;
  logic       err_control;

  d_phy_scnn dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .lp               (lp),
    .hs_clk_toggle    (hs_clk_toggle),
    .stopstate        (stopstate),
    .rx_clk_active_hs (rx_clk_active_hs),
    .rx_ulps_clk_not  (rx_ulps_clk_not),
    .ulps_active_not  (ulps_active_not),
    .hs_term_en       (hs_term_en),
    .err_control      (err_control)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         cyc;
    logic [5:0] exp;
    int         errs;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  logic mon_rst = 1'b0;

  // {stop, clk_active, ulps_clk_n, ulps_n, term_en, err}
  localparam logic [5:0] V_OFF   = 6'b001100;
  localparam logic [5:0] V_IDLE  = 6'b001100;
  localparam logic [5:0] V_STOP  = 6'b101100;
  localparam logic [5:0] V_PREP0 = 6'b001100;
  localparam logic [5:0] V_PREP1 = 6'b001110;
  localparam logic [5:0] V_HSCLK = 6'b011110;
  localparam logic [5:0] V_HSEND = 6'b001110;
  localparam logic [5:0] V_ULPS  = 6'b000000;
  localparam logic [5:0] V_UEXIT = 6'b001000;
  localparam logic [5:0] V_ERR1  = 6'b001101;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [5:0] act;
    act = {stopstate, rx_clk_active_hs, rx_ulps_clk_not,
           ulps_active_not, hs_term_en, err_control};
    if (mon_rst) err_seen = 0;
    else if (err_control === 1'b1) err_seen++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t c;
      c = q.pop_front();
      checks++;
      if (c.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale check cyc %0d at cyc %0d",
                 c.tag, c.cyc, cyc);
      end else if (act !== c.exp ||
                   (c.errs >= 0 && err_seen != c.errs)) begin
        errors++;
        $display("FAIL %s: outputs %b errs %0d, expected %b errs %0d",
                 c.tag, act, err_seen, c.exp, c.errs);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [5:0] v,
                            input int errs);
    chk_t c;
    c.tag  = tag;
    c.cyc  = cyc;
    c.exp  = v;
    c.errs = errs;
    q.push_back(c);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    lp = LP11;
    hs_clk_toggle = 1'b0;
    mon_rst = 1'b1;
    step(2);
    expect_out("reset_off", V_OFF, -1);
    step(1);
    mon_rst = 1'b0;
    rst = 1'b0;

    // init, with a 1-cycle Mark-1 glitch that must be filtered
    step(20);
    lp = LP10;
    step(1);
    lp = LP11;
    step(79);
    expect_out("init_not_yet", V_IDLE, 0);
    step(1);
    expect_out("init_stop", V_STOP, 0);

    // HS entry
    lp = LP01;
    step(3);
    expect_out("hs_rqst", V_IDLE, 0);
    lp = LP00;
    step(3);
    expect_out("hs_prep_entry", V_PREP0, 0);
    hs_clk_toggle = 1'b1;
    step(3);
    expect_out("hs_prep_early_toggle", V_PREP0, 0);
    step(1);
    expect_out("hs_term_en", V_PREP1, 0);
    step(1);
    expect_out("hs_clk", V_HSCLK, 0);

    // HS idle then resume, then LP11 racing a toggle
    hs_clk_toggle = 1'b0;
    step(7);
    expect_out("hs_miss7", V_HSCLK, 0);
    step(1);
    expect_out("hs_end", V_HSEND, 0);
    hs_clk_toggle = 1'b1;
    step(1);
    expect_out("hs_resume", V_HSCLK, 0);
    lp = LP11;
    step(2);
    expect_out("hs_lp11_pending", V_HSCLK, 0);
    step(1);
    expect_out("hs_exit_stop", V_STOP, 0);
    hs_clk_toggle = 1'b0;

    // ULPS with full wakeup
    lp = LP10;
    step(3);
    expect_out("ulps_rqst", V_IDLE, 0);
    lp = LP00;
    step(3);
    expect_out("ulps", V_ULPS, 0);
    lp = LP10;
    step(3);
    expect_out("ulps_exit", V_UEXIT, 0);
    step(997);
    lp = LP11;
    step(2);
    expect_out("ulps_exit_hold", V_UEXIT, 0);
    step(1);
    expect_out("ulps_wake_stop", V_STOP, 0);

    // LP00 straight from STOP
    lp = LP00;
    step(3);
    expect_out("err_entry", V_ERR1, 1);
    step(1);
    expect_out("err_one_cycle", V_IDLE, 1);
    lp = LP11;
    step(3);
    expect_out("err_recover", V_STOP, 1);

    // Early ULPS exit
    lp = LP10;
    step(3);
    lp = LP00;
    step(3);
    expect_out("ulps2", V_ULPS, 1);
    lp = LP10;
    step(500);
    lp = LP11;
    step(3);
    expect_out("ulps_short_err", V_ERR1, 2);
    step(1);
    expect_out("ulps_short_stop", V_STOP, 2);

    // Shutdown from HS_CLK
    lp = LP01;
    step(3);
    lp = LP00;
    step(3);
    hs_clk_toggle = 1'b1;
    step(5);
    expect_out("sd_hs_clk", V_HSCLK, 2);
    enable = 1'b0;
    step(1);
    expect_out("sd_off", V_OFF, 2);
    hs_clk_toggle = 1'b0;
    lp = LP11;
    enable = 1'b1;
    step(3);

    // Reset mid-operation from INIT
    expect_out("reinit", V_IDLE, 2);
    rst = 1'b1;
    step(1);
    expect_out("rst_mid", V_OFF, 2);
    rst = 1'b0;
    step(2);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/d_phy_scnn.md
D_PHY_SCNN -- requirements
Module: d_phy_scnn

Interface
REQ-001 Clocking is one clock and the reset is synchronous and active-high; all state changes on rising edge of clk.
REQ-002 Parameter LP_FILT, 2: consecutive equal samples required to accept a new LP line code.
REQ-003 Parameter T_INIT_CYC, 100: continuous LP11 cycles required in INIT.
REQ-004 Parameter T_TERM_EN_CYC, 4: cycles in LP00 before HS termination enables.
REQ-005 Parameter CLK_MISS_CYC, 8: toggle-free cycles that declare the HS clock stopped.
REQ-006 Parameter T_WAKEUP_CYC, 1000: minimum Mark-1 (LP10) cycles for a valid ULPS exit.
REQ-007 clk  in  1  sampling clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 enable  in  1  PPI Enable; 0 = shutdown.
REQ-010 lp  in  2  raw LP receiver outputs {Dp,Dn}.
REQ-011 hs_clk_toggle  in  1  HS clock receiver saw an edge this cycle.
REQ-012 stopstate  out  1  lane in Stop state.
REQ-013 rx_clk_active_hs  out  1  HS clock being received.
REQ-014 rx_ulps_clk_not  out  1  active-low ULPS-entered indication.
REQ-015 ulps_active_not  out  1  active-low ULPS active.
REQ-016 hs_term_en  out  1  HS termination enable.
REQ-017 err_control  out  1  one-cycle pulse on illegal LP sequence.

Function
REQ-018 Deglitcher SHALL update lp_filt only after lp holds a new value for LP_FILT consecutive cycles; the FSM uses lp_filt only.
REQ-019 Outputs SHALL be decoded from the registered state, valid in the first cycle of that state.
REQ-020 States: OFF, INIT, STOP, HS_RQST, HS_PREP, HS_CLK, HS_END, ULPS_RQST, ULPS, ULPS_EXIT, ERR.
REQ-021 enable=0 in any state SHALL force OFF next cycle; this overrides every other transition.
REQ-022 OFF: enable=1 -> INIT.
REQ-023 INIT: counter runs while lp_filt=LP11 and restarts on any other code; at T_INIT_CYC -> STOP.
REQ-024 STOP: stopstate=1; LP01 -> HS_RQST; LP10 -> ULPS_RQST; LP00 -> ERR.
REQ-025 HS_RQST: LP00 -> HS_PREP; LP11 -> STOP (abort, no error); LP10 -> ERR.
REQ-026 HS_PREP: hs_term_en=1 after T_TERM_EN_CYC cycles; first hs_clk_toggle with hs_term_en=1 -> HS_CLK; LP11 -> STOP.
REQ-027 HS_CLK: rx_clk_active_hs=1, hs_term_en=1; CLK_MISS_CYC cycles without toggle -> HS_END; LP11 -> STOP.
REQ-028 HS_END (HS trail or HS Tx Idle): hs_term_en=1; toggle -> HS_CLK; LP11 -> STOP.
REQ-029 The miss counter SHALL reset on every toggle and saturate at CLK_MISS_CYC.
REQ-030 ULPS_RQST: LP00 -> ULPS; LP11 -> STOP; LP01 -> ERR.
REQ-031 ULPS: rx_ulps_clk_not=0, ulps_active_not=0; LP10 -> ULPS_EXIT; LP01 or LP11 -> ERR.
REQ-032 ULPS_EXIT: rx_ulps_clk_not=1, ulps_active_not=0; counter counts LP10 cycles.
REQ-033 In ULPS_EXIT, LP11 after at least T_WAKEUP_CYC LP10 cycles SHALL go to STOP; LP11 before that SHALL go to ERR.
REQ-034 ERR: err_control=1 in the entry cycle only; lp_filt=LP11 -> STOP.
REQ-035 Simultaneous toggle and LP11 in HS_END or HS_CLK: LP11 wins.

Reset
REQ-036 rst=1 SHALL set state=OFF, all counters=0 and lp_filt=LP11.
REQ-037 In OFF, outputs SHALL be stopstate=0, rx_clk_active_hs=0, rx_ulps_clk_not=1, ulps_active_not=1, hs_term_en=0, err_control=0.
REQ-038 Reset mid-operation (any state) SHALL give these values in the next cycle.

Structure
REQ-039 The state enum, LP codes (LP00/01/10/11 as 2-bit constants) and default timing constants SHALL live in the shared D-PHY package.
REQ-040 The deglitcher SHALL be a sub-module named d_phy_lp_deglitch.

Verification
REQ-041 Init: rst, enable=1, lp=LP11 for 100+2 cycles -> stopstate=1; an LP10 glitch of 1 cycle during INIT does not restart the count.
REQ-042 HS entry: LP01, LP00, then toggles from cycle 6 -> hs_term_en=1 after 4 LP00 cycles; rx_clk_active_hs=1 at first toggle.
REQ-043 HS idle: toggles stop for 8 cycles -> HS_END with rx_clk_active_hs=0; toggles resume -> rx_clk_active_hs=1; LP11 -> stopstate=1, hs_term_en=0.
REQ-044 ULPS: LP10, LP00 -> ulps_active_not=0; LP10 for 1000 cycles, then LP11 -> stopstate=1, ulps_active_not=1, err_control never 1.
REQ-045 Errors: LP00 directly from STOP -> err_control high exactly 1 cycle; LP11 after 500 LP10 cycles in ULPS_EXIT -> err_control pulse.
REQ-046 Shutdown: enable=0 during HS_CLK -> next cycle all outputs at OFF values.
